// File: rtl/biquad_coeff_loader_if.sv
// Host and filter-side signal bundle for biquad_coeff_loader.
//   master : host/staging side (drives wr_*, go_i, abort_i; observes status and coeff bus)
//   slave  : the loader itself (drives busy/done/err and the coefficient bus)
// Signals:
//   wr_en_i, wr_addr_i[AW], wr_dat_i[18] : staging register write port
//   go_i, abort_i                        : start / cancel a load
//   busy_o, done_o, err_o                : status
//   coeff_dat_o[18], coeff_wr_o          : B1-stage coefficient bus and write strobe
//   coeff_update_o                       : B2-stage commit strobe
interface biquad_coeff_loader_if #(
    parameter int unsigned AW = 4
);
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [17:0]   wr_dat_i;
    logic          go_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [17:0]   coeff_dat_o;
    logic          coeff_wr_o;
    logic          coeff_update_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_dat_i, go_i, abort_i,
        input  busy_o, done_o, err_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_dat_i, go_i, abort_i,
        output busy_o, done_o, err_o, coeff_dat_o, coeff_wr_o, coeff_update_o
    );
endinterface

// File: rtl/biquad_coeff_loader.sv
// Coefficient loader for one biquad8 incremental filter.
// Host stages NCOEFF signed 18-bit coefficients, then pulses go. The loader shifts them into
// the DSP B1 cascade highest address first (coeff_wr_o), waits SETTLE cycles and commits them
// with a single coeff_update_o / done_o pulse. abort_i cancels a load in progress.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : biquad_coeff_loader_if.slave (staging port, control, status, coefficient bus)
module biquad_coeff_loader #(
    parameter int unsigned NCOEFF = 2,
    parameter int unsigned AW     = 4,
    parameter int unsigned GAP    = 0,
    parameter int unsigned SETTLE = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    biquad_coeff_loader_if.slave        bus
);

    typedef enum logic [2:0] {StIdle, StWrite, StGap, StSettle, StUpdate} state_e;

    localparam logic [4:0] KLast      = 5'(NCOEFF - 1);
    // Only reached when GAP/SETTLE are non-zero, so the wrap at zero is harmless.
    localparam logic [3:0] GapLast    = 4'(GAP - 1);
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [4:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [17:0] stage_q [NCOEFF];
    logic [17:0] stage_d [NCOEFF];
    logic [17:0] dat_q, dat_d;
    logic        wr_q, upd_q, err_q, err_d;
    logic        load;
    logic [4:0]  idx;

    logic [AW-1:0] addr;
    logic          busy, addr_ok, wr_ok, go_ok;

    assign addr    = bus.wr_addr_i;
    assign busy    = (state_q != StIdle);
    assign addr_ok = (32'(addr) < NCOEFF);
    assign wr_ok   = bus.wr_en_i && !busy && addr_ok;
    assign go_ok   = bus.go_i && !busy;

    // Staging file with the accepted write folded in, so a same-cycle go sees the new value.
    always_comb begin
        for (int unsigned i = 0; i < NCOEFF; i++) begin
            stage_d[i] = stage_q[i];
            if (wr_ok && (32'(addr) == i)) begin
                stage_d[i] = bus.wr_dat_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (go_ok) begin
                    state_d = StWrite;
                    k_d     = 5'd0;
                    load    = 1'b1;
                end
            end
            StWrite: begin
                if (k_q == KLast) begin
                    cnt_d   = 4'd0;
                    state_d = (SETTLE == 0) ? StUpdate : StSettle;
                end else if (GAP == 0) begin
                    k_d  = k_q + 5'd1;
                    load = 1'b1;
                end else begin
                    state_d = StGap;
                    cnt_d   = 4'd0;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = StWrite;
                    k_d     = k_q + 5'd1;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StUpdate;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StUpdate: begin
                state_d = StIdle;
                k_d     = 5'd0;
            end
            default: state_d = StIdle;
        endcase

        if (busy && bus.abort_i) begin
            state_d = StIdle;
            k_d     = 5'd0;
            cnt_d   = 4'd0;
            load    = 1'b0;
        end

        // Highest address goes out first.
        idx   = KLast - k_d;
        dat_d = dat_q;
        if (load) begin
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                if (idx == 5'(i)) begin
                    dat_d = stage_d[i];
                end
            end
        end

        // A rejected write wins over a same-cycle clear so no error is lost.
        err_d = err_q;
        if (go_ok) begin
            err_d = 1'b0;
        end
        if (bus.wr_en_i && (busy || !addr_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= 5'd0;
            cnt_q   <= 4'd0;
            dat_q   <= 18'd0;
            wr_q    <= 1'b0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                stage_q[i] <= 18'd0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            wr_q    <= load;
            upd_q   <= (state_d == StUpdate);
            err_q   <= err_d;
            for (int unsigned i = 0; i < NCOEFF; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign bus.busy_o         = busy;
    assign bus.done_o         = upd_q;
    assign bus.err_o          = err_q;
    assign bus.coeff_dat_o    = dat_q;
    assign bus.coeff_wr_o     = wr_q;
    assign bus.coeff_update_o = upd_q;

endmodule

// File: tb/tb_biquad_coeff_loader.sv
// Directed bench for biquad_coeff_loader: three instances cover
// (NCOEFF=2,GAP=0,SETTLE=2), (NCOEFF=2,GAP=3,SETTLE=2) and (NCOEFF=1,GAP=0,SETTLE=0).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_biquad_coeff_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    biquad_coeff_loader_if #(.AW(4)) a_if ();
    biquad_coeff_loader_if #(.AW(4)) b_if ();
    biquad_coeff_loader_if #(.AW(4)) c_if ();

    biquad_coeff_loader #(.NCOEFF(2), .AW(4), .GAP(0), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
    );
    biquad_coeff_loader #(.NCOEFF(2), .AW(4), .GAP(3), .SETTLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
    );
    biquad_coeff_loader #(.NCOEFF(1), .AW(4), .GAP(0), .SETTLE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(c_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, wr, update, done, data}
    function automatic logic [31:0] pk(input logic b, input logic w, input logic u,
                                       input logic d, input logic [17:0] dat);
        return {10'd0, b, w, u, d, dat};
    endfunction

    function automatic logic [31:0] obs_a();
        return pk(a_if.busy_o, a_if.coeff_wr_o, a_if.coeff_update_o, a_if.done_o,
                  a_if.coeff_dat_o);
    endfunction

    function automatic logic [31:0] obs_b();
        return pk(b_if.busy_o, b_if.coeff_wr_o, b_if.coeff_update_o, b_if.done_o,
                  b_if.coeff_dat_o);
    endfunction

    function automatic logic [31:0] obs_c();
        return pk(c_if.busy_o, c_if.coeff_wr_o, c_if.coeff_update_o, c_if.done_o,
                  c_if.coeff_dat_o);
    endfunction

    // Expected trace for a load of {3FFFF @1, 00123 @0}, cycle c after the go edge.
    function automatic logic [31:0] exp_a(input int c);
        case (c)
            1:       return pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h3FFFF);
            2:       return pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h00123);
            3, 4:    return pk(1'b1, 1'b0, 1'b0, 1'b0, 18'h00123);
            5:       return pk(1'b1, 1'b0, 1'b1, 1'b1, 18'h00123);
            default: return pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h00123);
        endcase
    endfunction

    function automatic logic [31:0] exp_b(input int c);
        case (c)
            1:       return pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h3FFFF);
            2, 3, 4: return pk(1'b1, 1'b0, 1'b0, 1'b0, 18'h3FFFF);
            5:       return pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h00123);
            6, 7:    return pk(1'b1, 1'b0, 1'b0, 1'b0, 18'h00123);
            8:       return pk(1'b1, 1'b0, 1'b1, 1'b1, 18'h00123);
            default: return pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h00123);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_if.wr_en_i = 1'b0; a_if.wr_addr_i = '0; a_if.wr_dat_i = '0;
        a_if.go_i = 1'b0; a_if.abort_i = 1'b0;
        b_if.wr_en_i = 1'b0; b_if.wr_addr_i = '0; b_if.wr_dat_i = '0;
        b_if.go_i = 1'b0; b_if.abort_i = 1'b0;
        c_if.wr_en_i = 1'b0; c_if.wr_addr_i = '0; c_if.wr_dat_i = '0;
        c_if.go_i = 1'b0; c_if.abort_i = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_a", obs_a(), pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h0));
        check("rst_err", {31'd0, a_if.err_o}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic load on A and gapped load on B
        a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 4'd0; a_if.wr_dat_i = 18'h00123;
        b_if.wr_en_i = 1'b1; b_if.wr_addr_i = 4'd0; b_if.wr_dat_i = 18'h00123;
        tick();
        a_if.wr_addr_i = 4'd1; a_if.wr_dat_i = 18'h3FFFF;
        b_if.wr_addr_i = 4'd1; b_if.wr_dat_i = 18'h3FFFF;
        tick();
        a_if.wr_en_i = 1'b0; b_if.wr_en_i = 1'b0;
        a_if.go_i = 1'b1; b_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0; b_if.go_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 6) check($sformatf("load_a_t%0d", c), obs_a(), exp_a(c));
            check($sformatf("gap_b_t%0d", c), obs_b(), exp_b(c));
            tick();
        end

        // Out-of-range write, then write while busy
        a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 4'd2; a_if.wr_dat_i = 18'h11111;
        tick();
        a_if.wr_en_i = 1'b0;
        check("err_bad_addr", {31'd0, a_if.err_o}, 32'd1);
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("err_go_clr", {31'd0, a_if.err_o}, 32'd0);
        check("err_t1", obs_a(), exp_a(1));
        a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 4'd0; a_if.wr_dat_i = 18'h2AAAA;
        tick();
        a_if.wr_en_i = 1'b0;
        check("err_busy_wr", {31'd0, a_if.err_o}, 32'd1);
        check("err_t2", obs_a(), exp_a(2));
        repeat (4) tick();
        check("err_sticky", {31'd0, a_if.err_o}, 32'd1);
        check("err_idle", obs_a(), exp_a(6));
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("err_clr2", {31'd0, a_if.err_o}, 32'd0);
        check("rb_t1", obs_a(), exp_a(1));
        tick();
        check("rb_t2_old", obs_a(), exp_a(2));
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("go_busy_no_err", {31'd0, a_if.err_o}, 32'd0);
        tick(); tick();
        check("rb_t5", obs_a(), exp_a(5));
        tick();
        check("go_busy_no_restart", obs_a(), exp_a(6));

        // Write and go in the same cycle
        a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 4'd1; a_if.wr_dat_i = 18'h15555; a_if.go_i = 1'b1;
        tick();
        a_if.wr_en_i = 1'b0; a_if.go_i = 1'b0;
        check("wrgo_t1", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h15555));
        tick();
        check("wrgo_t2", obs_a(), exp_a(2));
        repeat (4) tick();

        // Abort at T+2
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("abort_t1", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h15555));
        tick();
        a_if.abort_i = 1'b1;
        tick();
        a_if.abort_i = 1'b0;
        check("abort_t3", obs_a(), pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h00123));
        for (int c = 4; c <= 7; c++) begin
            check($sformatf("abort_quiet_t%0d", c),
                  {29'd0, a_if.coeff_wr_o, a_if.coeff_update_o, a_if.done_o}, 32'd0);
            tick();
        end
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("reload_t1", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h15555));
        repeat (4) tick();
        check("reload_t5", obs_a(), exp_a(5));
        tick();

        // Asynchronous reset mid-load
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("prerst_t1", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h15555));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", obs_a(), pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        a_if.go_i = 1'b1;
        tick();
        a_if.go_i = 1'b0;
        check("zero_t1", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h0));
        tick();
        check("zero_t2", obs_a(), pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h0));
        repeat (3) tick();
        check("zero_t5", obs_a(), pk(1'b1, 1'b0, 1'b1, 1'b1, 18'h0));
        tick();
        check("zero_t6", obs_a(), pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h0));

        // go held high, NCOEFF=1, SETTLE=0: three-cycle repeat
        c_if.wr_en_i = 1'b1; c_if.wr_addr_i = 4'd0; c_if.wr_dat_i = 18'h0ABCD;
        tick();
        c_if.wr_en_i = 1'b0;
        c_if.go_i = 1'b1;
        tick();
        for (int c = 1; c <= 9; c++) begin
            case ((c - 1) % 3)
                0:       check($sformatf("rep_t%0d", c), obs_c(),
                               pk(1'b1, 1'b1, 1'b0, 1'b0, 18'h0ABCD));
                1:       check($sformatf("rep_t%0d", c), obs_c(),
                               pk(1'b1, 1'b0, 1'b1, 1'b1, 18'h0ABCD));
                default: check($sformatf("rep_t%0d", c), obs_c(),
                               pk(1'b0, 1'b0, 1'b0, 1'b0, 18'h0ABCD));
            endcase
            tick();
        end
        c_if.go_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_loader.md
Name: biquad_coeff_loader

Overview:
- Drives the coefficient-load side of the biquad8 incremental filter: the 18-bit coefficient bus, the B1-stage write strobe and the B2-stage update strobe.
- Host logic stages NCOEFF coefficients in a register file, then issues go.
- The block shifts the coefficients into the DSP B-cascade highest address first, then commits them with a single update pulse.
- One instance feeds one filter; all DSP pairs in that filter share its coefficient bus.

Parameters:
- NCOEFF, 2, number of coefficients per load; one per cascade stage, range 1..16.
- AW, 4, host address width; must satisfy 2^AW >= NCOEFF.
- GAP, 0, idle cycles inserted between consecutive write strobes, range 0..15.
- SETTLE, 2, idle cycles between the last write strobe and the update strobe, range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  host staging write enable.
- wr_addr_i  in  AW  staging address.
- wr_dat_i  in  18  staging data (signed coefficient).
- go_i  in  1  start load, single-cycle pulse or level.
- abort_i  in  1  cancel a load in progress.
- busy_o  out  1  load sequence active.
- done_o  out  1  one-cycle pulse when the update strobe is issued.
- err_o  out  1  sticky error flag.
- coeff_dat_o  out  18  coefficient bus to the filter.
- coeff_wr_o  out  1  B1 write strobe to the filter.
- coeff_update_o  out  1  B2 update strobe to the filter.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, staging registers 0, FSM in IDLE, internal counters 0. Releasing reset returns the block to IDLE with no strobes.
- Staging write: when wr_en_i is high, busy_o is low and wr_addr_i < NCOEFF, stage[wr_addr_i] <= wr_dat_i at the edge.
- Rejected writes:
  - wr_addr_i >= NCOEFF: write dropped, err_o <= 1.
  - busy_o high: write dropped, err_o <= 1; the load in progress is unaffected.
- err_o clears only on an accepted go or on reset.
- Write and go in the same cycle: the write is accepted and the load uses the new value.
- IDLE:
  - go_i high at edge T: enter LOAD, busy_o = 1 from T+1, k = 0.
  - go_i while busy_o is high is ignored and does not set err_o.
- LOAD:
  - Write cycles: coeff_wr_o = 1 and coeff_dat_o = stage[NCOEFF-1-k].
  - After each write cycle, GAP cycles follow with coeff_wr_o = 0; coeff_dat_o holds its last value.
  - k increments after each write plus its gap.
  - After write k = NCOEFF-1, enter SETTLE; no gap follows the final write.
  - With GAP = 0, the write strobes occupy cycles T+1 .. T+NCOEFF.
- SETTLE: wait SETTLE cycles with both strobes low, then enter UPDATE.
- UPDATE (one cycle): coeff_update_o = 1 and done_o = 1. Next cycle: IDLE, busy_o = 0.
- Latency with GAP = 0: the update strobe occurs at T+NCOEFF+SETTLE+1; busy_o falls at T+NCOEFF+SETTLE+2.
- Back-to-back loads: go_i sampled in the cycle busy_o falls starts a new load immediately.
- abort_i:
  - High at any edge while busy_o is high: next cycle is IDLE, all strobes 0, busy_o = 0, no update or done pulse.
  - The B1 stage may hold partial data; a later full load overwrites it.
  - abort_i has priority over go_i in the same cycle.
  - abort_i in IDLE has no effect.
- Strobes and coeff_dat_o are driven directly from registers (no combinational path from inputs) so they can fan out to 2*NUM_DSPS DSP CE pins.
- coeff_dat_o: changes only on write cycles; otherwise it holds its value.

Test Plan:
- Stage 0x00123 at addr 0 and 0x3FFFF at addr 1, then pulse go at T (NCOEFF=2, GAP=0, SETTLE=2):
  - coeff_wr_o high at T+1 with data 0x3FFFF, and at T+2 with data 0x00123.
  - coeff_update_o and done_o high at T+5 only.
  - busy_o high T+1..T+5.
- GAP=3, NCOEFF=2:
  - write strobes at T+1 and T+5.
  - coeff_dat_o holds 0x3FFFF during T+2..T+4.
  - update at T+8.
- Write to addr 2 (NCOEFF=2), then write while busy:
  - both writes dropped; err_o = 1.
  - staging readback via a following load shows the old values.
  - next go clears err_o.
- abort_i high at T+2 of a load: no update pulse, busy_o = 0 at T+3, no further strobes; a new go completes normally.
- Assert rst_n low mid-LOAD: outputs 0 immediately, without a clock edge. After release, a load emits all-zero coefficients and then an update.
- go_i held high continuously with NCOEFF=1, SETTLE=0: loads repeat every 3 cycles, with update on the 2nd cycle of each and no lost or duplicated strobes.
